// File: rtl/cordic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_pkg : shared types and constants for the iterative CORDIC engine
// Revision   : 1.0
// ---------------------------------------------------------------------------
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam real CORDIC_GAIN = 1.6467602581210654;
  localparam real C_PI        = 3.14159265358979323846;

  // round(atan(2^-idx)/pi * 2^(width-1)); evaluated only at elaboration time
  function automatic longint atan_entry(input int width, input int idx);
    real r;
    r = $atan(2.0 ** (-idx)) / C_PI * (2.0 ** (width - 1));
    return longint'(r);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_atan_rom.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_atan_rom : combinational micro-rotation angle table, zero past WIDTH-1
// Revision        : 1.0
// ---------------------------------------------------------------------------
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IW    = 4
) (
  input  logic [IW-1:0]    i_idx,
  output logic [WIDTH-1:0] o_atan
);

  logic [WIDTH-1:0] tab [2**IW];

  for (genvar k = 0; k < 2**IW; k++) begin : g_tab
    if (k < WIDTH) begin : g_val
      assign tab[k] = WIDTH'(atan_entry(WIDTH, k));
    end else begin : g_zero
      assign tab[k] = '0;
    end
  end

  assign o_atan = tab[i_idx];

endmodule
`default_nettype wire

// File: rtl/cordic_iterative_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_iterative_engine : one circular CORDIC micro-rotation per clock,
//                           rotation or vectoring mode, gain not compensated
// Revision                : 1.0
// ---------------------------------------------------------------------------
module cordic_iterative_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 15,
  parameter int IW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out
);

  localparam logic [IW-1:0] LAST_I = IW'(ITER - 1);

  state_e                  state_q, state_d;
  logic [IW-1:0]           i_q, i_d;
  logic                    mode_q, mode_d;
  logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [WIDTH-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;

  logic                    w_ready, w_load, w_last, w_dir_pos;
  logic signed [WIDTH-1:0] w_x_sh, w_y_sh, w_atan;
  logic signed [WIDTH-1:0] w_x_nx, w_y_nx, w_z_nx;

  cordic_atan_rom #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_atan_rom (
    .i_idx  (i_q),
    .o_atan (w_atan)
  );

  assign w_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign w_load  = start && w_ready;
  assign w_last  = (state_q == ST_RUN) && (i_q == LAST_I);

  // Rotation drives z toward 0, vectoring drives y toward 0
  assign w_dir_pos = mode_q ? y_q[WIDTH-1] : ~z_q[WIDTH-1];
  assign w_x_sh    = x_q >>> i_q;
  assign w_y_sh    = y_q >>> i_q;
  assign w_x_nx    = w_dir_pos ? (x_q - w_y_sh) : (x_q + w_y_sh);
  assign w_y_nx    = w_dir_pos ? (y_q + w_x_sh) : (y_q - w_x_sh);
  assign w_z_nx    = w_dir_pos ? (z_q - w_atan) : (z_q + w_atan);

  always_ff @(posedge clk) begin : p_state
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : p_next
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (w_last) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : p_out
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  always_comb begin : p_datapath
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    i_d    = i_q;
    mode_d = mode_q;
    xo_d   = xo_q;
    yo_d   = yo_q;
    zo_d   = zo_q;
    if (w_load) begin
      x_d    = x_in;
      y_d    = y_in;
      z_d    = z_in;
      i_d    = '0;
      mode_d = mode;
    end else if (state_q == ST_RUN) begin
      x_d = w_x_nx;
      y_d = w_y_nx;
      z_d = w_z_nx;
      i_d = i_q + 1'b1;
      // Results land on the same edge that raises done
      if (w_last) begin
        xo_d = w_x_nx;
        yo_d = w_y_nx;
        zo_d = w_z_nx;
      end
    end
  end

  always_ff @(posedge clk) begin : p_regs
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      i_q    <= '0;
      mode_q <= 1'b0;
      xo_q   <= '0;
      yo_q   <= '0;
      zo_q   <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      i_q    <= i_d;
      mode_q <= mode_d;
      xo_q   <= xo_d;
      yo_q   <= yo_d;
      zo_q   <= zo_d;
    end
  end

  assign x_out = xo_q;
  assign y_out = yo_q;
  assign z_out = zo_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_iterative_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cordic_iterative_engine : directed and randomised checks of the CORDIC engine
// Revision                   : 1.0
// ---------------------------------------------------------------------------
module tb_cordic_iterative_engine;

  localparam int  WIDTH = 16;
  localparam int  ITER  = 15;
  localparam int  IW    = 4;
  localparam real PI    = 3.14159265358979323846;
  localparam real K     = 1.6467602581210654;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               mode = 1'b0;
  logic signed [15:0] x_in = '0, y_in = '0, z_in = '0;
  logic               busy, done;
  logic signed [15:0] x_out, y_out, z_out;

  int vectors     = 0;
  int miscompares = 0;

  cordic_iterative_engine #(
    .WIDTH (WIDTH),
    .ITER  (ITER),
    .IW    (IW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .x_in  (x_in),
    .y_in  (y_in),
    .z_in  (z_in),
    .busy  (busy),
    .done  (done),
    .x_out (x_out),
    .y_out (y_out),
    .z_out (z_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input longint obs, input real exp, input int tol);
    real diff;
    bit  ok;
    diff = real'(obs) - exp;
    ok   = (diff <= real'(tol)) && (diff >= -real'(tol));
    vectors++;
    assert (ok === 1'b1) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0.2f+/-%0d", tag, obs, exp, tol);
    end
  endtask

  // Plain software CORDIC with WIDTH-bit wrapping arithmetic
  task automatic model(input bit m, input logic signed [15:0] xi, yi, zi,
                       output logic signed [15:0] xo, yo, zo);
    logic signed [15:0] xv, yv, zv, xs, ys, a;
    bit                 pos;
    xv = xi; yv = yi; zv = zi;
    for (int k = 0; k < ITER; k++) begin
      a   = 16'(int'($atan(2.0 ** (-k)) / PI * 32768.0));
      pos = m ? (yv < 0) : (zv >= 0);
      xs  = xv >>> k;
      ys  = yv >>> k;
      if (pos) begin
        xv = xv - ys; yv = yv + xs; zv = zv - a;
      end else begin
        xv = xv + ys; yv = yv - xs; zv = zv + a;
      end
    end
    xo = xv; yo = yv; zo = zv;
  endtask

  task automatic start_op(input bit m, input logic signed [15:0] xi, yi, zi);
    start = 1'b1; mode = m; x_in = xi; y_in = yi; z_in = zi;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles after the accepting edge (first cycle = 1) until done
  task automatic wait_done(input int first, output int cyc, output bit both);
    cyc  = first;
    both = 1'b0;
    while (!done && cyc < 100) begin
      if (busy && done) both = 1'b1;
      tick();
      cyc++;
    end
    if (busy && done) both = 1'b1;
  endtask

  task automatic run_check(input string tag, input bit m, input logic signed [15:0] xi, yi, zi);
    logic signed [15:0] ex, ey, ez;
    int cyc;
    bit both;
    model(m, xi, yi, zi, ex, ey, ez);
    start_op(m, xi, yi, zi);
    wait_done(1, cyc, both);
    chk({tag, "_latency"}, cyc, ITER + 1);
    chk({tag, "_busy_done_overlap"}, both, 0);
    chk({tag, "_x"}, x_out, ex);
    chk({tag, "_y"}, y_out, ey);
    chk({tag, "_z"}, z_out, ez);
  endtask

  initial begin : p_stim
    logic signed [15:0] ex, ey, ez, ax, ay, az;
    int  cyc, ndone, dcyc;
    bit  both;
    real th, xr, yr;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_z_out", z_out, 0);
    rst = 1'b0;
    tick();

    // Rotation by 45 degrees
    run_check("rot45", 1'b0, 16'sd9949, 16'sd0, 16'sd8192);
    chk_tol("rot45_x_tol", x_out, 11585.0, 4);
    chk_tol("rot45_y_tol", y_out, 11585.0, 4);
    chk_tol("rot45_z_tol", z_out, 0.0, 2);

    // Pure gain
    run_check("gain", 1'b0, 16'sd1000, 16'sd0, 16'sd0);
    chk_tol("gain_x_tol", x_out, 1647.0, 2);
    chk_tol("gain_y_tol", y_out, 0.0, 2);

    // Vectoring at 45 degrees
    run_check("vec45", 1'b1, 16'sd12288, 16'sd12288, 16'sd0);
    chk_tol("vec45_x_tol", x_out, 28618.0, 4);
    chk_tol("vec45_y_tol", y_out, 0.0, 2);
    chk_tol("vec45_z_tol", z_out, 8192.0, 2);

    // Start pulses while busy are ignored
    model(1'b0, 16'sd5000, -16'sd2000, 16'sd4000, ex, ey, ez);
    start_op(1'b0, 16'sd5000, -16'sd2000, 16'sd4000);
    ndone = 0; dcyc = 0;
    for (int c = 1; c < 40; c++) begin
      start = (c == 3) || (c == 10);
      mode  = 1'b1;
      x_in  = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
      tick();
      if (done) begin
        ndone++;
        dcyc = c + 1;
        ax = x_out; ay = y_out; az = z_out;
      end
    end
    start = 1'b0;
    chk("ignore_done_count", ndone, 1);
    chk("ignore_done_cycle", dcyc, ITER + 1);
    chk("ignore_x", ax, ex);
    chk("ignore_y", ay, ey);
    chk("ignore_z", az, ez);

    // Back-to-back: start in the done cycle, outputs hold during the second run
    model(1'b0, 16'sd3000, 16'sd1000, -16'sd6000, ex, ey, ez);
    start_op(1'b0, 16'sd3000, 16'sd1000, -16'sd6000);
    wait_done(1, cyc, both);
    chk("b2b_first_latency", cyc, ITER + 1);
    chk("b2b_first_x", x_out, ex);
    model(1'b1, 16'sd7000, -16'sd4000, 16'sd100, ax, ay, az);
    start_op(1'b1, 16'sd7000, -16'sd4000, 16'sd100);
    chk("b2b_busy_after_accept", busy, 1);
    repeat (4) tick();
    chk("b2b_hold_x", x_out, ex);
    chk("b2b_hold_z", z_out, ez);
    wait_done(5, cyc, both);
    chk("b2b_second_latency", cyc, ITER + 1);
    chk("b2b_second_x", x_out, ax);
    chk("b2b_second_y", y_out, ay);
    chk("b2b_second_z", z_out, az);
    tick();
    chk("b2b_done_single_pulse", done, 0);

    // Reset in the middle of an operation
    start_op(1'b0, 16'sd4000, 16'sd0, 16'sd2000);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_x_out", x_out, 0);
    chk("midrst_y_out", y_out, 0);
    chk("midrst_z_out", z_out, 0);
    ndone = 0;
    repeat (20) begin
      tick();
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    run_check("after_rst", 1'b0, 16'sd4000, 16'sd0, 16'sd2000);

    // Randomised sweep
    for (int n = 0; n < 24; n++) begin
      bit                 m;
      logic signed [15:0] rx, ry, rz;
      m  = 1'($urandom_range(1));
      ry = 16'(int'($urandom_range(12000)) - 6000);
      if (m) begin
        rx = 16'(int'($urandom_range(6000)));
        rz = 16'(int'($urandom_range(8000)) - 4000);
      end else begin
        rx = 16'(int'($urandom_range(12000)) - 6000);
        rz = 16'(int'($urandom_range(32768)) - 16384);
      end
      run_check(m ? "rand_vec" : "rand_rot", m, rx, ry, rz);
      if (!m) begin
        th = real'(rz) * PI / 32768.0;
        xr = K * (real'(rx) * $cos(th) - real'(ry) * $sin(th));
        yr = K * (real'(rx) * $sin(th) + real'(ry) * $cos(th));
        chk_tol("rand_rot_x_trig", x_out, xr, 8);
        chk_tol("rand_rot_y_trig", y_out, yr, 8);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
